// File: rtl/ntt_pkg.sv
// Shared encodings for the NTT address scheduler: operation modes, FSM states
// and the LOG_N / NUM_LAYERS legality check.
package ntt_pkg;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'b00,
        MODE_INTT = 2'b01,
        MODE_IN   = 2'b10,
        MODE_OUT  = 2'b11
    } ntt_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } ntt_state_e;

    function automatic bit ntt_params_ok(input int log_n, input int num_layers);
        return (log_n >= 2) && (num_layers >= 1) && (num_layers <= log_n - 1);
    endfunction

endpackage

// File: rtl/ntt_bfly_addr.sv
// Butterfly address pair: inserts a zero at bit s of the butterfly counter to
// form the top address; the bottom address sets that bit.
module ntt_bfly_addr #(
    parameter int LOG_N = 8
) (
    input  logic [LOG_N-2:0]         cnt,
    input  logic [$clog2(LOG_N)-1:0] s,
    output logic [LOG_N-1:0]         addr_a,
    output logic [LOG_N-1:0]         addr_b
);

    logic [LOG_N-1:0] cnt_w;
    logic [LOG_N-1:0] bit_s;
    logic [LOG_N-1:0] lo_mask;

    always_comb begin
        cnt_w   = {1'b0, cnt};
        bit_s   = LOG_N'(1) << s;
        lo_mask = bit_s - LOG_N'(1);
        addr_a  = ((cnt_w & ~lo_mask) << 1) | (cnt_w & lo_mask);
        addr_b  = addr_a | bit_s;
    end

endmodule

// File: rtl/ntt_addr_sched.sv
// Address / twiddle-index scheduler for forward NTT, inverse NTT and sequential
// load/store, with valid/ready output and an optional drain gap between layers.
module ntt_addr_sched
    import ntt_pkg::*;
#(
    parameter int LOG_N      = 8,
    parameter int NUM_LAYERS = 7,
    parameter int GAP        = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    output logic                        busy,
    output logic                        addr_vld,
    input  logic                        addr_rdy,
    output logic [LOG_N-1:0]            addr_a,
    output logic [LOG_N-1:0]            addr_b,
    output logic [NUM_LAYERS-1:0]       tw_idx,
    output logic [$clog2(NUM_LAYERS):0] layer,
    output logic                        layer_last,
    output logic                        last,
    output logic                        done
);

    localparam int SW = $clog2(LOG_N);
    localparam int LW = $clog2(NUM_LAYERS) + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = NUM_LAYERS + 1;

    if (!ntt_params_ok(LOG_N, NUM_LAYERS)) begin : g_param_check
        $error("ntt_addr_sched: NUM_LAYERS must lie in 1..LOG_N-1");
    end

    ntt_state_e            state, state_nxt;
    ntt_mode_e             mode_r, mode_nxt;
    // Full LOG_N width so the sequential modes can count to N-1; butterfly
    // modes only use the low LOG_N-1 bits.
    logic [LOG_N-1:0]      cnt, cnt_nxt;
    logic [LW-1:0]         l, l_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    logic                  load, vld_nxt, done_nxt, fire;
    logic [SW-1:0]         s_nxt;
    logic [LOG_N-1:0]      bf_a, bf_b, a_nxt, b_nxt;
    logic [NUM_LAYERS-1:0] tw_nxt;
    logic [LW-1:0]         layer_nxt;
    logic                  ll_nxt, last_nxt;

    assign fire = addr_vld && addr_rdy;

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        cnt_nxt   = cnt;
        l_nxt     = l;
        gap_nxt   = gap_cnt;
        load      = 1'b0;
        vld_nxt   = addr_vld;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nxt  = ntt_mode_e'(mode);
                    cnt_nxt   = '0;
                    l_nxt     = '0;
                    load      = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (last) begin
                        vld_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else if (layer_last) begin
                        cnt_nxt = '0;
                        l_nxt   = l + LW'(1);
                        if (GAP > 0) begin
                            vld_nxt   = 1'b0;
                            gap_nxt   = GW'(GAP - 1);
                            state_nxt = S_DRAIN;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + LOG_N'(1);
                        load    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (gap_cnt == '0) begin
                    load      = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    gap_nxt = gap_cnt - GW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NTT walks strides downward from N/2; INTT walks them upward from the
    // smallest stride implied by NUM_LAYERS.
    assign s_nxt = (mode_nxt == MODE_INTT) ? SW'(LOG_N - NUM_LAYERS) + SW'(l_nxt)
                                           : SW'(LOG_N - 1) - SW'(l_nxt);

    ntt_bfly_addr #(.LOG_N(LOG_N)) u_bfly_addr (
        .cnt    (cnt_nxt[LOG_N-2:0]),
        .s      (s_nxt),
        .addr_a (bf_a),
        .addr_b (bf_b)
    );

    always_comb begin
        a_nxt     = bf_a;
        b_nxt     = bf_b;
        tw_nxt    = '0;
        layer_nxt = l_nxt;
        ll_nxt    = &cnt_nxt[LOG_N-2:0];
        last_nxt  = 1'b0;
        if (mode_nxt[1]) begin
            a_nxt     = cnt_nxt;
            b_nxt     = cnt_nxt;
            layer_nxt = '0;
            ll_nxt    = &cnt_nxt;
            last_nxt  = ll_nxt;
        end else begin
            last_nxt = ll_nxt && (l_nxt == LW'(NUM_LAYERS - 1));
            if (mode_nxt == MODE_INTT)
                tw_nxt = NUM_LAYERS'((TW'(1) << (LW'(NUM_LAYERS) - l_nxt)) - TW'(1)
                                     - TW'(cnt_nxt[LOG_N-2:0] >> s_nxt));
            else
                tw_nxt = NUM_LAYERS'((TW'(1) << l_nxt) + TW'(cnt_nxt[LOG_N-2:0] >> s_nxt));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_r     <= MODE_NTT;
            cnt        <= '0;
            l          <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            addr_vld   <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            tw_idx     <= '0;
            layer      <= '0;
            layer_last <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_r   <= mode_nxt;
            cnt      <= cnt_nxt;
            l        <= l_nxt;
            gap_cnt  <= gap_nxt;
            busy     <= (state_nxt != S_IDLE);
            addr_vld <= vld_nxt;
            done     <= done_nxt;
            if (load) begin
                addr_a     <= a_nxt;
                addr_b     <= b_nxt;
                tw_idx     <= tw_nxt;
                layer      <= layer_nxt;
                layer_last <= ll_nxt;
                last       <= last_nxt;
            end else if (!vld_nxt) begin
                layer_last <= 1'b0;
                last       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ntt_addr_sched.sv
// Directed bench for ntt_addr_sched: NTT, INTT, gap, backpressure, IN/OUT and
// mid-operation reset, against a loop-structured reference ordering.
module tb_ntt_addr_sched;

    localparam int LOG_N = 8;
    localparam int NL    = 7;
    localparam int N     = 1 << LOG_N;
    localparam int HALF  = N / 2;
    localparam int LW    = $clog2(NL) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_g = 1'b0;
    logic addr_rdy = 1'b1;
    logic [1:0] mode = 2'b00;
    logic use_g = 1'b0;

    logic busy0, vld0, ll0, last0, done0;
    logic [LOG_N-1:0] a0, b0;
    logic [NL-1:0] tw0;
    logic [LW-1:0] ly0;
    logic busy3, vld3, ll3, last3, done3;
    logic [LOG_N-1:0] a3, b3;
    logic [NL-1:0] tw3;
    logic [LW-1:0] ly3;

    logic busy, vld, ll, lst, done;
    logic [LOG_N-1:0] a, b;
    logic [NL-1:0] tw;
    logic [LW-1:0] ly;
    logic [31:0] obs;

    assign busy = use_g ? busy3 : busy0;
    assign vld  = use_g ? vld3  : vld0;
    assign ll   = use_g ? ll3   : ll0;
    assign lst  = use_g ? last3 : last0;
    assign done = use_g ? done3 : done0;
    assign a    = use_g ? a3    : a0;
    assign b    = use_g ? b3    : b0;
    assign tw   = use_g ? tw3   : tw0;
    assign ly   = use_g ? ly3   : ly0;
    assign obs  = {3'b000, a, b, tw, ly, ll, lst};

    ntt_addr_sched #(.LOG_N(LOG_N), .NUM_LAYERS(NL), .GAP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy0),
        .addr_vld(vld0), .addr_rdy(addr_rdy), .addr_a(a0), .addr_b(b0),
        .tw_idx(tw0), .layer(ly0), .layer_last(ll0), .last(last0), .done(done0)
    );

    ntt_addr_sched #(.LOG_N(LOG_N), .NUM_LAYERS(NL), .GAP(3)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .mode(mode), .busy(busy3),
        .addr_vld(vld3), .addr_rdy(addr_rdy), .addr_a(a3), .addr_b(b3),
        .tw_idx(tw3), .layer(ly3), .layer_last(ll3), .last(last3), .done(done3)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    int spot_i[$];
    logic [31:0] spot_v[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input int pa, input int pb, input int pt,
                                       input int pl, input bit pll, input bit pla);
        logic [7:0] a8, b8;
        logic [6:0] t7;
        logic [3:0] l4;
        a8 = pa[7:0];
        b8 = pb[7:0];
        t7 = pt[6:0];
        l4 = pl[3:0];
        return {3'b000, a8, b8, t7, l4, pll, pla};
    endfunction

    // Reference ordering written as the textbook nested loops over strides and groups.
    task automatic build(input logic [1:0] m);
        exp_q.delete();
        if (m[1]) begin
            for (int i = 0; i < N; i++)
                exp_q.push_back(pk(i, i, 0, 0, i == N - 1, i == N - 1));
        end else begin
            int k;
            k = (m == 2'b00) ? 1 : (1 << NL) - 1;
            for (int l = 0; l < NL; l++) begin
                int len;
                int idx;
                len = (m == 2'b00) ? (HALF >> l) : ((N >> NL) << l);
                idx = 0;
                for (int st = 0; st < N; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        exp_q.push_back(pk(j, j + len, k, l, idx == HALF - 1,
                                           (idx == HALF - 1) && (l == NL - 1)));
                        idx++;
                    end
                    if (m == 2'b00) k++;
                    else k--;
                end
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] m, input bit g,
                          input int bp_at, input int extra_at, input int exp_done);
        int ntx, cyc, stall, gap_run, done_cyc;
        bit in_gap;
        logic [31:0] held;
        build(m);
        use_g = g;
        mode = m;
        if (g) start_g = 1'b1;
        else start = 1'b1;
        tick;
        start = 1'b0;
        start_g = 1'b0;
        mode = ~m;
        cyc = 1; ntx = 0; stall = 0; gap_run = 0; done_cyc = -1; in_gap = 1'b0; held = '0;
        chk({nm, " busy@1"}, 32'(busy), 1);
        while (cyc < 3000) begin
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (vld) begin
                if (in_gap) begin
                    chk({nm, " gap"}, gap_run, g ? 3 : 0);
                    in_gap = 1'b0;
                end
                if (ntx == bp_at - 1 && stall < 5) begin
                    if (stall == 0) held = obs;
                    else chk({nm, " hold"}, obs, held);
                    addr_rdy = 1'b0;
                    stall++;
                end else begin
                    addr_rdy = 1'b1;
                    if (ntx < exp_q.size()) chk($sformatf("%s tx%0d", nm, ntx), obs, exp_q[ntx]);
                    else chk({nm, " extra tx"}, ntx, exp_q.size());
                    for (int i = 0; i < spot_i.size(); i++)
                        if (spot_i[i] == ntx) chk($sformatf("%s spot%0d", nm, ntx), obs, spot_v[i]);
                    if (ntx == extra_at) start = 1'b1;
                    ntx++;
                    if (ll && !lst) begin
                        in_gap = 1'b1;
                        gap_run = 0;
                    end
                end
            end else if (in_gap) begin
                gap_run++;
            end
            tick;
            cyc++;
        end
        addr_rdy = 1'b1;
        chk({nm, " done cycle"}, done_cyc, exp_done);
        chk({nm, " transfers"}, ntx, exp_q.size());
        chk({nm, " busy@done"}, 32'(busy), 1);
        tick;
        chk({nm, " done 1cyc"}, 32'(done), 0);
        chk({nm, " busy after"}, 32'(busy), 0);
        spot_i.delete();
        spot_v.delete();
    endtask

    initial begin
        int ntx;
        bit saw;
        repeat (3) tick;
        chk("reset outs", obs, 0);
        chk("reset ctl", {busy0, vld0, done0, busy3, vld3, done3}, 0);
        chk("reset outs gap dut", {a3, b3, tw3, ly3, ll3, last3}, 0);
        rst = 1'b0;
        tick;

        spot_i = '{0, 127, 128, 895};
        spot_v = '{pk(0, 128, 1, 0, 0, 0), pk(127, 255, 1, 0, 1, 0),
                   pk(0, 64, 2, 1, 0, 0), pk(253, 255, 127, 6, 1, 1)};
        run_op("ntt", 2'b00, 1'b0, -10, -1, 897);

        spot_i = '{0, 1, 2, 895};
        spot_v = '{pk(0, 2, 127, 0, 0, 0), pk(1, 3, 127, 0, 0, 0),
                   pk(4, 6, 126, 0, 0, 0), pk(127, 255, 1, 6, 1, 1)};
        run_op("intt", 2'b01, 1'b0, -10, -1, 897);

        spot_i = '{0, 895};
        spot_v = '{pk(0, 128, 1, 0, 0, 0), pk(253, 255, 127, 6, 1, 1)};
        run_op("ntt gap3", 2'b00, 1'b1, -10, -1, 915);

        spot_i = '{2};
        spot_v = '{pk(2, 130, 1, 0, 0, 0)};
        run_op("ntt bp", 2'b00, 1'b0, 3, -1, 902);

        spot_i = '{0, 10, 11, 255};
        spot_v = '{pk(0, 0, 0, 0, 0, 0), pk(10, 10, 0, 0, 0, 0),
                   pk(11, 11, 0, 0, 0, 0), pk(255, 255, 0, 0, 1, 1)};
        run_op("in", 2'b10, 1'b0, -10, 10, 257);

        spot_i = '{100};
        spot_v = '{pk(100, 100, 0, 0, 0, 0)};
        run_op("out", 2'b11, 1'b0, -10, -1, 257);

        build(2'b00);
        use_g = 1'b0;
        mode = 2'b00;
        start = 1'b1;
        tick;
        start = 1'b0;
        ntx = 0;
        for (int i = 0; i < 400 && ntx < 199; i++) begin
            if (vld && addr_rdy) ntx++;
            tick;
        end
        chk("rst pre tx200", obs, exp_q[199]);
        rst = 1'b1;
        #1;
        chk("rst async outs", obs, 0);
        chk("rst async ctl", {busy, vld, done}, 0);
        saw = 1'b0;
        repeat (3) begin
            tick;
            if (done) saw = 1'b1;
        end
        rst = 1'b0;
        tick;
        if (done) saw = 1'b1;
        chk("rst no done", 32'(saw), 0);
        chk("rst idle busy", 32'(busy), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart first", obs, pk(0, 128, 1, 0, 0, 0));
        chk("restart vld", 32'(vld), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_addr_sched.md
# ntt_addr_sched

Parametrised address and twiddle-index scheduler for the NTT datapath. It replaces the fixed 256-point counter-based generator with a start/done controlled engine covering forward NTT (Cooley-Tukey), inverse NTT (Gentleman-Sande), and sequential load/store. The butterfly unit and coefficient BRAM consume its outputs through a valid/ready handshake. It inserts a programmable drain gap between layers so butterfly results are written back before the next layer reads them.

## Interface
- LOG_N, 8, log2 of polynomial length N; N = 2^LOG_N.
- NUM_LAYERS, 7, butterfly layers per transform; 1 ≤ NUM_LAYERS ≤ LOG_N-1.
- GAP, 0, idle cycles inserted between consecutive NTT/INTT layers; 0 means no bubble.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- mode  in  2  00 NTT, 01 INTT, 10 IN, 11 OUT; sampled on the accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- addr_vld  out  1  address/twiddle outputs valid.
- addr_rdy  in  1  consumer accepts; transfer occurs when addr_vld && addr_rdy.
- addr_a  out  LOG_N  butterfly top address; sequential address in IN/OUT.
- addr_b  out  LOG_N  addr_a + len; equals addr_a in IN/OUT.
- tw_idx  out  NUM_LAYERS  twiddle (zeta) ROM index; 0 in IN/OUT.
- layer  out  clog2(NUM_LAYERS)+1  current layer index; 0 in IN/OUT.
- layer_last  out  1  marks the final transfer of a layer.
- last  out  1  marks the final transfer of the operation.
- done  out  1  one-cycle pulse after the final transfer.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN on the last transfer of a non-final layer when GAP > 0; with GAP = 0, RUN moves straight to the next layer.
  - DRAIN → RUN after GAP cycles.
  - RUN → DONE on the final transfer.
  - DONE → IDLE after one cycle.
- Internal counters: butterfly counter cnt, width LOG_N-1, range 0..N/2-1 per layer; layer counter l.
- NTT, layer l:
  - s = LOG_N-1-l; len = 2^s.
  - addr_a = cnt with a 0 bit inserted at position s, i.e. {cnt[LOG_N-2:s], 0, cnt[s-1:0]}.
  - addr_b = addr_a | len.
  - tw_idx = 2^l + (cnt >> s).
- INTT, layer l:
  - s = LOG_N-NUM_LAYERS+l; addresses formed as in NTT.
  - tw_idx = 2^(NUM_LAYERS-l) - 1 - (cnt >> s).
- Transfer counts:
  - NTT/INTT: NUM_LAYERS × N/2 transfers (896 at the defaults).
  - IN/OUT: N transfers, addr_a = addr_b = 0..N-1, no gaps.
- Boundary and conflict rules:
  - start while busy: ignored.
  - mode changes after start: ignored; the latched mode is used.
  - cnt wraps to 0 at each layer boundary.
  - The last transfer asserts last and layer_last together.
- All arithmetic is unsigned; tw_idx never exceeds 2^NUM_LAYERS - 1.

## Timing
- Reset values: busy, addr_vld, addr_a, addr_b, tw_idx, layer, layer_last, last, done all 0; state IDLE.
- Start latency: start at cycle 0 → addr_vld = 1 with the first address at cycle 1.
- All outputs are registered. With addr_rdy held high, one transfer per cycle.
- Backpressure: while addr_vld && !addr_rdy, every output holds stable.
- DRAIN: addr_vld = 0 for exactly GAP cycles; the next layer's first address appears the cycle after DRAIN ends.
- done pulses the cycle after the final transfer; busy falls one cycle after done.
- Completion time with rdy = 1 (start at cycle 0): done at cycle NUM_LAYERS × N/2 + (NUM_LAYERS-1) × GAP + 1, e.g. 897 for NTT with GAP = 0.
- rst asserted at any time, including mid-operation: outputs clear immediately; no done pulse is issued.

## Structure
- Shared package ntt_pkg holds:
  - mode encodings NTT/INTT/IN/OUT;
  - FSM state encoding;
  - LOG_N/NUM_LAYERS legality check.
- Sub-module ntt_bfly_addr (combinational): given cnt and s, returns addr_a and addr_b. Instantiated once.
- The twiddle formula, FSM, and counters live in the top module.

## Test plan
- NTT, defaults, rdy = 1:
  - transfer 1: a=0, b=128, tw=1;
  - transfer 129: a=0, b=64, tw=2, layer=1;
  - transfer 896: a=253, b=255, tw=127, last=1;
  - done at cycle 897.
- INTT, defaults:
  - transfers 1–3: (a=0, b=2, tw=127), (a=1, b=3, tw=127), (a=4, b=6, tw=126);
  - final transfer: a=127, b=255, tw=1, layer=6.
- NTT, GAP=3: exactly 3 cycles with addr_vld=0 after each layer_last except the final one; done at cycle 915.
- Backpressure: addr_rdy low for 5 cycles while transfer 3 (a=2, b=130) is presented → outputs held, no address skipped, total 896 transfers.
- IN mode: 256 transfers with a=b=0..255, tw=0; last on 255. A start pulse at transfer 10 is ignored.
- rst mid-NTT at transfer 200:
  - all outputs 0 immediately, no done pulse;
  - a new start restarts with a=0, b=128, tw=1.
